// File: rtl/mac_accumulator.sv
// Saturating signed multiply-accumulate stage: sums TERMS products (or fewer on
// flush) and holds the result over a valid/ready handshake until consumed.
module mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20,
  parameter int TERMS  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              in_sub,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_r;

  logic             accept;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_term;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // One guard bit above ACC_W: overflow shows as disagreement of the top two bits.
  always_comb begin
    prod_ext  = {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
    acc_ext   = {acc[ACC_W-1], acc};
    sum       = in_sub ? (acc_ext - prod_ext) : (acc_ext + prod_ext);
    sum_ovf   = (sum[ACC_W] != sum[ACC_W-1]);
    sum_sat   = sum_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    cnt_inc   = cnt + CNT_W'(1);
    last_term = (cnt_inc == CNT_W'(TERMS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= sum_sat;
            cnt   <= cnt_inc;
            ovf_r <= ovf_r | sum_ovf;
            state <= (last_term || flush) ? HOLD : ACCUM;
          end else if (flush && state == ACCUM) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc_out  = acc;
  assign term_cnt = cnt;
  assign ovf      = ovf_r;

endmodule
